// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - ping-pong line-buffer controller driving an external dual-port RAM
module line_buf_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 11,
    parameter int LINE_WIDTH    = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    input  logic                     line_repeat,
    output logic [1:0]               bank_full,
    output logic [ADDRESS_WIDTH-1:0] ram_addrA,
    output logic [DATA_WIDTH-1:0]    ram_dataA,
    output logic                     ram_weA,
    output logic [ADDRESS_WIDTH-1:0] ram_addrB,
    output logic                     ram_weB,
    input  logic [DATA_WIDTH-1:0]    ram_qB
);
    localparam int CW = ADDRESS_WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(LINE_WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t                   state, state_nxt;
    logic                     rst_q;
    logic                     wr_bank, rd_bank;
    logic [CW-1:0]            wr_cnt, rd_cnt, rd_cnt_nxt;
    logic [1:0]               full_set, bank_full_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_b_q;
    logic                     inflight, inflight_last;
    logic [DATA_WIDTH-1:0]    fifo_data [2];
    logic [1:0]               fifo_last;
    logic                     fifo_head;
    logic [1:0]               fifo_count;
    logic [2:0]               credit;
    logic                     in_beat, wr_done, issue, pop, rd_release, fifo_tail;

    assign in_ready  = !rst && !rst_q && !bank_full[wr_bank];
    assign in_beat   = in_valid && in_ready;
    assign wr_done   = in_beat && (wr_cnt == LAST);
    assign ram_weA   = in_beat;
    assign ram_addrA = {wr_bank, wr_cnt};
    assign ram_dataA = in_data;
    assign ram_weB   = 1'b0;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[fifo_head];
    assign out_last  = out_valid && fifo_last[fifo_head];
    assign pop       = out_valid && out_ready;
    assign fifo_tail = fifo_head ^ fifo_count[0];

    // Credits cover FIFO occupancy plus the read still in the RAM pipeline.
    assign credit    = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign ram_addrB = issue ? {rd_bank, rd_cnt} : addr_b_q;

    always_comb begin
        full_set = bank_full;
        if (wr_done)
            full_set[wr_bank] = 1'b1;
        state_nxt  = state;
        rd_cnt_nxt = rd_cnt;
        rd_release = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (full_set[rd_bank]) begin
                    state_nxt  = READ;
                    rd_cnt_nxt = '0;
                end
            end
            READ: begin
                issue = (credit < 3'd2);
                if (issue) begin
                    if (rd_cnt == LAST) begin
                        rd_cnt_nxt = '0;
                        if (!line_repeat) begin
                            rd_release = 1'b1;
                            // Chain straight into the other bank to keep 1 pixel/cycle.
                            state_nxt  = full_set[!rd_bank] ? READ : IDLE;
                        end
                    end else begin
                        rd_cnt_nxt = rd_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        bank_full_nxt = full_set;
        if (rd_release)
            bank_full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q         <= 1'b1;
            state         <= IDLE;
            bank_full     <= 2'b00;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            addr_b_q      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= 2'b00;
            fifo_head     <= 1'b0;
            fifo_count    <= 2'd0;
        end else begin
            rst_q     <= 1'b0;
            state     <= state_nxt;
            bank_full <= bank_full_nxt;
            rd_cnt    <= rd_cnt_nxt;
            addr_b_q  <= ram_addrB;
            if (rd_release)
                rd_bank <= !rd_bank;
            if (in_beat) begin
                if (wr_done) begin
                    wr_cnt  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            inflight      <= issue;
            inflight_last <= issue && (rd_cnt == LAST);
            if (inflight) begin
                fifo_data[fifo_tail] <= ram_qB;
                fifo_last[fifo_tail] <= inflight_last;
            end
            fifo_head  <= fifo_head ^ pop;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb/tb_line_buf_ctrl.sv - self-checking bench for line_buf_ctrl with an attached RAM model
module tb_line_buf_ctrl;
    localparam int LW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       line_repeat = 1'b0;
    logic [1:0] bank_full;
    logic [3:0] ram_addrA, ram_addrB;
    logic [7:0] ram_dataA;
    logic       ram_weA, ram_weB;
    logic [7:0] ram_qB = '0;
    logic [7:0] mem [16];

    line_buf_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .line_repeat(line_repeat), .bank_full(bank_full),
        .ram_addrA(ram_addrA), .ram_dataA(ram_dataA), .ram_weA(ram_weA),
        .ram_addrB(ram_addrB), .ram_weB(ram_weB), .ram_qB(ram_qB)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_weA) mem[ram_addrA] <= ram_dataA;
        ram_qB <= mem[ram_addrB];
    end

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         first_ov, last_in_cyc, stall_n, wea_bad, hold_viol;
    logic       rst_nx = 1'b1;
    logic       acc;
    logic       hold_pending;
    logic [7:0] hold_data;
    logic [7:0] acc_q [$];
    logic [3:0] addr_q [$];
    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    int         obs_cyc [$];
    logic [1:0] bf_hist [int];
    logic [7:0] pix [32];

    task automatic tick(input logic iv, input logic [7:0] id, input logic ordy, input logic rep);
        @(negedge clk);
        rst = rst_nx; in_valid = iv; in_data = id; out_ready = ordy; line_repeat = rep;
        #1;
        cyc++;
        acc = in_valid && in_ready;
        bf_hist[cyc] = bank_full;
        if (ram_weA !== acc) wea_bad++;
        if (in_valid && !in_ready) stall_n++;
        if (acc) begin
            acc_q.push_back(in_data);
            addr_q.push_back(ram_addrA);
            last_in_cyc = cyc;
        end
        if (hold_pending && (!out_valid || out_data !== hold_data)) hold_viol++;
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            obs_q.push_back({out_last, out_data});
            obs_cyc.push_back(cyc);
        end
    endtask

    function automatic void clear_state();
        acc_q.delete(); addr_q.delete(); obs_q.delete(); obs_cyc.delete(); bf_hist.delete();
        first_ov = -1; last_in_cyc = -1; stall_n = 0; wea_bad = 0; hold_viol = 0;
        hold_pending = 1'b0;
    endfunction

    task automatic do_reset();
        rst_nx = 1'b1;
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 0, 0);
        rst_nx = 1'b0;
        tick(0, 8'h00, 0, 0);
        clear_state();
    endtask

    // Reference: every LW accepted pixels form a line; a line is emitted once per pass.
    function automatic void build_exp(input int line0_passes);
        exp_q.delete();
        for (int l = 0; l < acc_q.size() / LW; l++)
            for (int p = 0; p < ((l == 0) ? line0_passes : 1); p++)
                for (int k = 0; k < LW; k++)
                    exp_q.push_back({1'(k == LW - 1), acc_q[l * LW + k]});
    endfunction

    task automatic drain(input int n, input int budget, input logic rand_rdy);
        int g = 0;
        while (obs_q.size() < n && g < budget) begin
            tick(0, 8'h00, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 0);
            g++;
        end
    endtask

    task automatic test_reset();
        rst_nx = 1'b1;
        tick(0, 8'h00, 1, 0);
        tick(0, 8'h00, 1, 0);
        n_vec += 9;
        if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (out_last !== 1'b0)  begin n_err++; $display("FAIL rst_out_last got %b want 0", out_last); end
        if (ram_weA !== 1'b0)   begin n_err++; $display("FAIL rst_weA got %b want 0", ram_weA); end
        if (ram_weB !== 1'b0)   begin n_err++; $display("FAIL rst_weB got %b want 0", ram_weB); end
        if (bank_full !== 2'b00) begin n_err++; $display("FAIL rst_bank_full got %b want 00", bank_full); end
        if (ram_addrA !== 4'h0) begin n_err++; $display("FAIL rst_addrA got %h want 0", ram_addrA); end
        if (ram_addrB !== 4'h0) begin n_err++; $display("FAIL rst_addrB got %h want 0", ram_addrB); end
        if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got %h want 00", out_data); end
        rst_nx = 1'b0;
        tick(0, 8'h00, 1, 0);
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_q_in_ready got %b want 0", in_ready); end
        tick(0, 8'h00, 1, 0);
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
        clear_state();
    endtask

    task automatic test_single_line();
        do_reset();
        for (int i = 0; i < LW; i++) tick(1, 8'h10 + 8'(i), 1, 0);
        drain(LW, 60, 0);
        build_exp(1);
        n_vec += 4;
        if (acc_q.size() != LW) begin n_err++; $display("FAIL single_accepted got %0d want %0d", acc_q.size(), LW); end
        if (bf_hist[last_in_cyc + 1] !== 2'b01) begin
            n_err++; $display("FAIL single_bank_full got %b want 01", bf_hist[last_in_cyc + 1]);
        end
        if (first_ov != last_in_cyc + 3) begin
            n_err++; $display("FAIL single_latency got %0d want %0d", first_ov - last_in_cyc, 3);
        end
        if (bank_full !== 2'b00) begin n_err++; $display("FAIL single_release got %b want 00", bank_full); end
        for (int i = 0; i < addr_q.size(); i++) begin
            n_vec++;
            if (addr_q[i] !== 4'(i)) begin n_err++; $display("FAIL single_addrA[%0d] got %h want %h", i, addr_q[i], 4'(i)); end
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i] || obs_cyc[i] != first_ov + i) begin
                n_err++; $display("FAIL single_out[%0d] got %h@%0d want %h@%0d", i, obs_q[i], obs_cyc[i], exp_q[i], first_ov + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int g = 0;
        do_reset();
        for (int i = 0; i < 32; i++) pix[i] = 8'($urandom);
        while (idx < 32 && g < 200) begin
            tick(1, pix[idx], 1, 0);
            if (acc) idx++;
            g++;
        end
        drain(32, 100, 0);
        build_exp(1);
        n_vec += 3;
        if (stall_n != 0) begin n_err++; $display("FAIL b2b_in_ready_drops got %0d want 0", stall_n); end
        if (wea_bad != 0) begin n_err++; $display("FAIL b2b_weA got %0d bad cycles want 0", wea_bad); end
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < addr_q.size(); i++) begin
            n_vec++;
            if (addr_q[i] !== 4'(((i / LW) % 2) * LW + i % LW)) begin
                n_err++; $display("FAIL b2b_addrA[%0d] got %h want %h", i, addr_q[i], 4'(((i / LW) % 2) * LW + i % LW));
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int g = 0;
        logic rose = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) pix[i] = 8'($urandom);
        while (idx < 16 && g < 100) begin
            tick(1, pix[idx], 0, 0);
            if (acc) idx++;
            g++;
        end
        tick(1, pix[16], 0, 0);
        n_vec += 3;
        if (bank_full !== 2'b11) begin n_err++; $display("FAIL bp_bank_full got %b want 11", bank_full); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        if (ram_weA !== 1'b0) begin n_err++; $display("FAIL bp_weA got %b want 0", ram_weA); end
        g = 0;
        while (!rose && g < 60) begin
            tick(1, pix[16], 1, 0);
            if (in_ready) begin
                rose = 1'b1;
                n_vec++;
                if (bf_hist[cyc - 1][0] !== 1'b1 || bank_full[0] !== 1'b0) begin
                    n_err++; $display("FAIL bp_release got %b->%b want 1->0", bf_hist[cyc - 1][0], bank_full[0]);
                end
            end
            g++;
        end
        n_vec++;
        if (!rose) begin n_err++; $display("FAIL bp_in_ready_rise got 0 want 1 within 60 cycles"); end
        drain(16, 100, 0);
        build_exp(1);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_ready();
        int idx = 0;
        int g = 0;
        do_reset();
        for (int i = 0; i < 24; i++) pix[i] = 8'($urandom);
        while (idx < 24 && g < 600) begin
            tick(1'($urandom_range(0, 3) != 0), pix[idx], 1'($urandom_range(0, 1)), 0);
            if (acc) idx++;
            g++;
        end
        drain(24, 600, 1);
        build_exp(1);
        n_vec += 2;
        if (hold_viol != 0) begin n_err++; $display("FAIL rand_hold got %0d changes want 0", hold_viol); end
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_replay();
        int   idx = 0;
        int   g = 0;
        logic rep = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
        while (obs_q.size() < 3 * LW && g < 300) begin
            tick(idx < 16, (idx < 16) ? pix[idx] : 8'h00, 1, rep);
            if (acc) idx++;
            if (obs_q.size() > 0 && obs_q[obs_q.size() - 1][8]) rep = 1'b0;
            g++;
        end
        repeat (10) tick(0, 8'h00, 1, 0);
        build_exp(2);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL replay_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL replay_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, 8'hA0 + 8'(i), 1, 0);
        rst_nx = 1'b1;
        tick(0, 8'h00, 1, 0);
        tick(0, 8'h00, 1, 0);
        n_vec++;
        if ({in_ready, out_valid, out_last, ram_weA, ram_weB, bank_full, ram_addrA, ram_addrB, out_data} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs got rdy=%b ov=%b ol=%b weA=%b weB=%b bf=%b aA=%h aB=%h od=%h want all 0",
                     in_ready, out_valid, out_last, ram_weA, ram_weB, bank_full, ram_addrA, ram_addrB, out_data);
        end
        rst_nx = 1'b0;
        tick(0, 8'h00, 1, 0);
        clear_state();
        for (int i = 0; i < LW; i++) tick(1, 8'h50 + 8'(i), 1, 0);
        drain(LW, 60, 0);
        repeat (20) tick(0, 8'h00, 1, 0);
        build_exp(1);
        n_vec++;
        if (obs_q.size() != LW) begin n_err++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), LW); end
        for (int i = 0; i < addr_q.size(); i++) begin
            n_vec++;
            if (addr_q[i] !== 4'(i)) begin n_err++; $display("FAIL midrst_addrA[%0d] got %h want %h", i, addr_q[i], 4'(i)); end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        clear_state();
        test_reset();
        test_single_line();
        test_back_to_back();
        test_backpressure();
        test_random_ready();
        test_replay();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
